// File: rtl/misao_pkg.sv
// Shared types and widths for the MISA-O nibble fetch path.
package misao_pkg;

  localparam int NIB_W   = 4;
  localparam int PC_W    = 16;
  localparam int BADDR_W = 15;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0002;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [NIB_W-1:0] data;
  } fetch_entry_t;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } req_state_e;

endpackage

// File: rtl/misao_nib_fifo.sv
// Nibble FIFO: up to two entries written per cycle, one popped, synchronous flush.
module misao_nib_fifo
  import misao_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  localparam int             AW       = $clog2(DEPTH),
  localparam int             CW       = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [1:0]   push_n,
  input  fetch_entry_t push_e0,
  input  fetch_entry_t push_e1,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr1;

  assign wr_ptr1 = wr_ptr + 1'b1;
  assign head    = mem[rd_ptr];

  // Storage is reset so the head reads {RESET_PC, 0} before anything is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: RESET_PC, data: '0};
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_n != 2'd0 && wr_ptr == AW'(i))
          mem[i] <= push_e0;
        else if (push_n == 2'd2 && wr_ptr1 == AW'(i))
          mem[i] <= push_e1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

endmodule

// File: rtl/misao_fetch.sv
// Nibble prefetch: byte reads from program memory, split into PC-tagged nibbles.
module misao_fetch
  import misao_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [BADDR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [7:0]         mem_data_in,
  output logic               nib_valid,
  input  logic               nib_ready,
  output logic [NIB_W-1:0]   nib_data,
  output logic [PC_W-1:0]    nib_pc,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  req_state_e         state, state_nxt;
  logic [PC_W-1:0]    fetch_pc;
  logic [BADDR_W-1:0] req_addr;
  logic               drop;
  logic               issue, ack_in, accept, pop;
  logic [CW-1:0]      count, free;
  logic [1:0]         push_n;
  fetch_entry_t       push_e0, push_e1, head;

  assign free   = CW'(DEPTH) - count;
  assign ack_in = (state == REQ_WAIT) && mem_ack;
  assign accept = ack_in && !drop && !redir_valid;

  assign mem_req   = (state == REQ_WAIT);
  assign mem_addr  = (state == REQ_WAIT) ? req_addr : fetch_pc[PC_W-1:1];
  assign nib_valid = (count != '0);
  assign nib_data  = head.data;
  assign nib_pc    = head.pc;
  assign pop       = nib_valid && nib_ready && !redir_valid;

  // A redirect during WAIT keeps the bus request alive; drop swallows its ack.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      REQ_IDLE: if (!redir_valid && free >= CW'(2)) begin
        state_nxt = REQ_WAIT;
        issue     = 1'b1;
      end
      REQ_WAIT: if (mem_ack) state_nxt = REQ_IDLE;
      default:  state_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REQ_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drop <= 1'b0;
    else if (ack_in)                           drop <= 1'b0;
    else if (redir_valid && state == REQ_WAIT) drop <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     req_addr <= RESET_PC[PC_W-1:1];
    else if (issue) req_addr <= fetch_pc[PC_W-1:1];
  end

  // Odd PC only follows a redirect: the even nibble of that byte is skipped.
  always_comb begin
    push_n  = 2'd0;
    push_e0 = '0;
    push_e1 = '0;
    if (accept) begin
      if (!fetch_pc[0]) begin
        push_n  = 2'd2;
        push_e0 = '{pc: fetch_pc,        data: mem_data_in[3:0]};
        push_e1 = '{pc: fetch_pc + 1'b1, data: mem_data_in[7:4]};
      end else begin
        push_n  = 2'd1;
        push_e0 = '{pc: fetch_pc,        data: mem_data_in[7:4]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           fetch_pc <= RESET_PC;
    else if (redir_valid) fetch_pc <= redir_pc;
    else if (accept)      fetch_pc <= fetch_pc + PC_W'(push_n);
  end

  misao_nib_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redir_valid),
    .push_n  (push_n),
    .push_e0 (push_e0),
    .push_e1 (push_e1),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

endmodule
